corr_peak_tracker: RTL and testbench

Downstream controller for the correlation scorer: sweeps the search template across every candidate window of the stored frame and collects one score per window. Start each correlation via a coordinate pair plus a start strobe, then wait for the scorer's finished flag. Keep the running maximum score and its window coordinates. Publish the best match to the display/overlay logic once the sweep ends.

---
 rtl/corr_pkg.sv | 25 ++
 rtl/corr_pos_stepper.sv | 39 +++
 rtl/corr_peak_tracker.sv | 132 +++++++++++++
 tb/tb_corr_peak_tracker.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// Shared widths, FSM encoding and origin-limit helper for the correlation
// scorer and its peak-tracking controller.
package corr_pkg;

  localparam int COORD_W = 13;
  localparam int SCORE_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_GUARD   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_COMPARE = 3'd4,
    ST_ADVANCE = 3'd5,
    ST_DONE    = 3'd6
  } corrState_t;

  // Largest multiple of step that still keeps the template inside the frame.
  function automatic logic [COORD_W-1:0] lastOrigin(input int frameRes,
                                                    input int searchRes,
                                                    input int step);
    return COORD_W'(((frameRes - searchRes) / step) * step);
  endfunction

endpackage

// File: rtl/corr_pos_stepper.sv
// Raster-order window origin counter: X advances fastest, wraps to 0 and
// steps Y; isLast flags the final origin of the sweep.
module corr_pos_stepper
  import corr_pkg::*;
#(
  parameter logic [COORD_W-1:0] LAST_X = '0,
  parameter logic [COORD_W-1:0] LAST_Y = '0,
  parameter int                 STEP   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               advance,
  output logic [COORD_W-1:0] posX,
  output logic [COORD_W-1:0] posY,
  output logic               isLast
);

  localparam logic [COORD_W-1:0] STEP_C = COORD_W'(STEP);

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      posX <= '0;
      posY <= '0;
    end else if (advance) begin
      if (posX >= LAST_X) begin
        posX <= '0;
        posY <= posY + STEP_C;
      end else begin
        posX <= posX + STEP_C;
      end
    end
  end

  assign isLast = (posX == LAST_X) && (posY == LAST_Y);

endmodule

// File: rtl/corr_peak_tracker.sv
// Sweeps the template over every candidate window, launches one scorer run
// per window and keeps the earliest highest-scoring origin.
module corr_peak_tracker
  import corr_pkg::*;
#(
  parameter int FRAME_H_RES    = 640,
  parameter int FRAME_V_RES    = 480,
  parameter int SEARCH_H_RES   = 32,
  parameter int SEARCH_V_RES   = 32,
  parameter int STEP           = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iStart,
  output logic [COORD_W-1:0] oXstart,
  output logic [COORD_W-1:0] oYstart,
  output logic               oCorrStart,
  input  logic               iFinished,
  input  logic [SCORE_W-1:0] iScore,
  output logic               oBusy,
  output logic               oDone,
  output logic               oValid,
  output logic [COORD_W-1:0] oBestX,
  output logic [COORD_W-1:0] oBestY,
  output logic [SCORE_W-1:0] oBestScore,
  output logic               oTimeout
);

  localparam logic [COORD_W-1:0] LAST_X = lastOrigin(FRAME_H_RES, SEARCH_H_RES, STEP);
  localparam logic [COORD_W-1:0] LAST_Y = lastOrigin(FRAME_V_RES, SEARCH_V_RES, STEP);
  localparam int                 CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  if (SEARCH_H_RES > FRAME_H_RES || SEARCH_V_RES > FRAME_V_RES) begin : gBadSearch
    $error("corr_peak_tracker: search template larger than frame");
  end
  if (STEP < 1 || TIMEOUT_CYCLES < 1) begin : gBadStep
    $error("corr_peak_tracker: STEP and TIMEOUT_CYCLES must be at least 1");
  end

  corrState_t         state;
  logic [CNT_W-1:0]   waitCnt;
  logic [SCORE_W-1:0] scoreReg;
  logic               haveScore;
  logic               isLast;

  corr_pos_stepper #(
    .LAST_X (LAST_X),
    .LAST_Y (LAST_Y),
    .STEP   (STEP)
  ) uStepper (
    .clk     (iCLK),
    .rst     (iRST),
    .clear   (state == ST_IDLE && iStart),
    .advance (state == ST_ADVANCE && !isLast),
    .posX    (oXstart),
    .posY    (oYstart),
    .isLast  (isLast)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state      <= ST_IDLE;
      waitCnt    <= '0;
      scoreReg   <= '0;
      haveScore  <= 1'b0;
      oBestX     <= '0;
      oBestY     <= '0;
      oBestScore <= '0;
      oValid     <= 1'b0;
      oTimeout   <= 1'b0;
    end else begin
      // NOTE: the default arm keeps an illegal encoding from sticking the FSM.
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            state      <= ST_ISSUE;
            haveScore  <= 1'b0;
            oBestX     <= '0;
            oBestY     <= '0;
            oBestScore <= '0;
            oValid     <= 1'b0;
            oTimeout   <= 1'b0;
          end
        end
        ST_ISSUE: state <= ST_GUARD;
        // The scorer's finished flag may still reflect the previous window.
        ST_GUARD: begin
          waitCnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (iFinished) begin
            scoreReg <= iScore;
            state    <= ST_COMPARE;
          end else if (waitCnt == CNT_LAST) begin
            oTimeout <= 1'b1;
            state    <= ST_ADVANCE;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        ST_COMPARE: begin
          // Strict compare: ties keep the earliest raster position.
          if (!haveScore || scoreReg > oBestScore) begin
            oBestScore <= scoreReg;
            oBestX     <= oXstart;
            oBestY     <= oYstart;
          end
          haveScore <= 1'b1;
          state     <= ST_ADVANCE;
        end
        ST_ADVANCE: begin
          if (isLast) begin
            oValid <= 1'b1;
            state  <= ST_DONE;
          end else begin
            state <= ST_ISSUE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign oCorrStart = (state == ST_ISSUE) && !iRST;
  assign oBusy      = (state != ST_IDLE);
  assign oDone      = (state == ST_DONE);

endmodule

// File: tb/tb_corr_peak_tracker.sv
// Randomized bench for corr_peak_tracker on an 8x6 frame with a 4x4 template
// and step 2, using a behavioural scorer and a best-match reference model.
module tb_corr_peak_tracker;
  import corr_pkg::*;

  localparam int FH = 8, FV = 6, SH = 4, SV = 4, ST = 2, TO = 16;
  localparam int NX = (FH - SH) / ST + 1;
  localparam int NY = (FV - SV) / ST + 1;
  localparam int NW = NX * NY;
  localparam logic [SCORE_W-1:0] STALE_SCORE = 16'hFFFF;

  logic               iCLK = 1'b0;
  logic               iRST = 1'b1;
  logic               iStart = 1'b0;
  logic               iFinished = 1'b0;
  logic [SCORE_W-1:0] iScore = '0;
  logic [COORD_W-1:0] oXstart, oYstart, oBestX, oBestY;
  logic [SCORE_W-1:0] oBestScore;
  logic               oCorrStart, oBusy, oDone, oValid, oTimeout;

  int checks = 0;
  int failures = 0;

  always #10 iCLK = ~iCLK;

  corr_peak_tracker #(
    .FRAME_H_RES(FH), .FRAME_V_RES(FV), .SEARCH_H_RES(SH), .SEARCH_V_RES(SV),
    .STEP(ST), .TIMEOUT_CYCLES(TO)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .oXstart(oXstart), .oYstart(oYstart),
    .oCorrStart(oCorrStart), .iFinished(iFinished), .iScore(iScore), .oBusy(oBusy),
    .oDone(oDone), .oValid(oValid), .oBestX(oBestX), .oBestY(oBestY),
    .oBestScore(oBestScore), .oTimeout(oTimeout)
  );

  // Per-window scorer behaviour, indexed in raster order.
  logic [SCORE_W-1:0] scoreTab [NW];
  bit                 stallTab [NW];
  bit                 staleMode = 1'b0;

  // Scorer model: clears on start (or keeps a stale high flag for two cycles),
  // then raises finished with the table score after a random latency.
  int lat = 0, staleLeft = 0, curIdx = 0;
  bit pend = 1'b0;
  always @(negedge iCLK) begin
    if (iRST) begin
      iFinished = 1'b0;
      iScore    = '0;
      pend      = 1'b0;
      staleLeft = 0;
    end else if (oCorrStart) begin
      curIdx    = int'(oYstart) / ST * NX + int'(oXstart) / ST;
      lat       = staleMode ? int'($urandom_range(6, 3)) : int'($urandom_range(6, 2));
      pend      = !stallTab[curIdx];
      staleLeft = staleMode ? 2 : 0;
      if (staleMode) begin
        iFinished = 1'b1;
        iScore    = STALE_SCORE;
      end else begin
        iFinished = 1'b0;
      end
    end else if (pend) begin
      if (staleLeft > 0) staleLeft--;
      lat--;
      if (lat == 0) begin
        iFinished = 1'b1;
        iScore    = scoreTab[curIdx];
        pend      = 1'b0;
      end else if (staleMode && staleLeft == 0) begin
        iFinished = 1'b0;
      end
    end
  end

  // Observed start pulses, origins and done pulses.
  int startCnt = 0, doneCnt = 0;
  int qX[$], qY[$];
  always @(negedge iCLK) begin
    if (oCorrStart) begin
      startCnt++;
      qX.push_back(int'(oXstart));
      qY.push_back(int'(oYstart));
    end
    if (oDone) doneCnt++;
  end

  task automatic clearTables();
    for (int i = 0; i < NW; i++) begin
      scoreTab[i] = '0;
      stallTab[i] = 1'b0;
    end
    staleMode = 1'b0;
  endtask

  task automatic randomScores(input int maxScore);
    for (int i = 0; i < NW; i++) scoreTab[i] = SCORE_W'($urandom_range(maxScore, 0));
  endtask

  // One full sweep plus all end-of-sweep comparisons against the model.
  task automatic runSweep(input string name, input bit busyPulses);
    int s0, d0, q0, cyc, k;
    bit have, expTo, orderOk;
    logic [SCORE_W-1:0] expScore;
    logic [COORD_W-1:0] expX, expY;

    have = 0; expTo = 0; expScore = '0; expX = '0; expY = '0; k = 0;
    for (int y = 0; y <= FV - SV; y += ST) begin
      for (int x = 0; x <= FH - SH; x += ST) begin
        if (stallTab[k]) expTo = 1;
        else if (!have || scoreTab[k] > expScore) begin
          have = 1; expScore = scoreTab[k]; expX = COORD_W'(x); expY = COORD_W'(y);
        end
        k++;
      end
    end

    s0 = startCnt; d0 = doneCnt; q0 = qX.size();
    @(negedge iCLK) iStart = 1'b1;
    @(negedge iCLK) iStart = 1'b0;
    checks++;
    if (oBusy !== 1'b1 || oValid !== 1'b0 || oTimeout !== 1'b0) begin
      failures++;
      $display("FAIL %s_start busy=%b valid=%b timeout=%b, expected busy=1 valid=0 timeout=0",
               name, oBusy, oValid, oTimeout);
    end

    cyc = 0;
    while (1) begin
      @(negedge iCLK);
      cyc++;
      if (oDone === 1'b1 || cyc >= 2000) break;
      iStart = busyPulses && (cyc % 7 == 3);
    end
    iStart = 1'b0;
    checks++;
    if (cyc >= 2000) begin
      failures++;
      $display("FAIL %s_done_wait no oDone within %0d cycles", name, cyc);
      return;
    end
    checks++;
    if (oValid !== 1'b1) begin
      failures++;
      $display("FAIL %s_valid_at_done got=%b expected=1", name, oValid);
    end

    @(negedge iCLK);
    checks++;
    if (oDone !== 1'b0 || oBusy !== 1'b0) begin
      failures++;
      $display("FAIL %s_after_done done=%b busy=%b, expected 0 0", name, oDone, oBusy);
    end
    checks++;
    if (oBestScore !== expScore) begin
      failures++;
      $display("FAIL %s_best_score got=%0d expected=%0d", name, oBestScore, expScore);
    end
    checks++;
    if (oBestX !== expX || oBestY !== expY) begin
      failures++;
      $display("FAIL %s_best_xy got=(%0d,%0d) expected=(%0d,%0d)", name, oBestX, oBestY, expX, expY);
    end
    checks++;
    if (oValid !== 1'b1 || oTimeout !== expTo) begin
      failures++;
      $display("FAIL %s_flags valid=%b timeout=%b, expected 1 %b", name, oValid, oTimeout, expTo);
    end
    checks++;
    if (startCnt - s0 != NW || doneCnt - d0 != 1) begin
      failures++;
      $display("FAIL %s_pulses corrStart=%0d done=%0d, expected %0d 1",
               name, startCnt - s0, doneCnt - d0, NW);
    end
    orderOk = 1; k = q0;
    for (int y = 0; y <= FV - SV; y += ST) begin
      for (int x = 0; x <= FH - SH; x += ST) begin
        if (k >= qX.size() || qX[k] != x || qY[k] != y) orderOk = 0;
        k++;
      end
    end
    checks++;
    if (!orderOk || qX.size() != q0 + NW) begin
      failures++;
      $display("FAIL %s_origin_order got %0d origins, first=(%0d,%0d), expected raster of %0d",
               name, qX.size() - q0, (qX.size() > q0) ? qX[q0] : -1,
               (qY.size() > q0) ? qY[q0] : -1, NW);
    end
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    repeat (3) @(negedge iCLK);
    checks++;
    if ({oBusy, oDone, oValid, oCorrStart, oTimeout, oXstart, oYstart,
         oBestX, oBestY, oBestScore} !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b done=%b valid=%b cs=%b to=%b x=%0d y=%0d best=%0d@(%0d,%0d), expected all 0",
               oBusy, oDone, oValid, oCorrStart, oTimeout, oXstart, oYstart, oBestScore, oBestX, oBestY);
    end
    iRST = 1'b0;
    @(negedge iCLK);
  endtask

  task automatic test_directed();
    logic [SCORE_W-1:0] tab [NW] = '{16'd10, 16'd30, 16'd20, 16'd5, 16'd30, 16'd7};
    clearTables();
    for (int i = 0; i < NW; i++) scoreTab[i] = tab[i];
    runSweep("directed", 1'b0);
    checks++;
    if (oBestScore !== 16'd30 || oBestX !== 13'd2 || oBestY !== 13'd0) begin
      failures++;
      $display("FAIL directed_literal got %0d@(%0d,%0d) expected 30@(2,0)", oBestScore, oBestX, oBestY);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      clearTables();
      randomScores((r < 2) ? 6 : 1000);
      runSweep($sformatf("random%0d", r), 1'b0);
    end
  endtask

  task automatic test_stale_finished();
    for (int r = 0; r < 2; r++) begin
      clearTables();
      randomScores(500);
      staleMode = 1'b1;
      runSweep($sformatf("stale%0d", r), 1'b0);
    end
    staleMode = 1'b0;
  endtask

  task automatic test_timeout();
    clearTables();
    randomScores(300);
    stallTab[2] = 1'b1;
    runSweep("timeout_one", 1'b0);
    clearTables();
    randomScores(300);
    stallTab[0] = 1'b1;
    stallTab[$urandom_range(NW - 1, 1)] = 1'b1;
    runSweep("timeout_two", 1'b0);
    clearTables();
    randomScores(300);
    for (int i = 0; i < NW; i++) stallTab[i] = 1'b1;
    runSweep("timeout_all", 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    int s0, cyc;
    clearTables();
    randomScores(100);
    stallTab[1] = 1'b1;
    s0 = startCnt;
    @(negedge iCLK) iStart = 1'b1;
    @(negedge iCLK) iStart = 1'b0;
    cyc = 0;
    while (startCnt - s0 < 2 && cyc < 500) begin
      @(negedge iCLK);
      cyc++;
    end
    repeat (4) @(negedge iCLK);
    checks++;
    if (oBusy !== 1'b1) begin
      failures++;
      $display("FAIL midwait_busy_before_reset got=%b expected=1 (starts seen=%0d)", oBusy, startCnt - s0);
    end
    iRST = 1'b1;
    @(negedge iCLK);
    checks++;
    if ({oBusy, oDone, oValid, oCorrStart, oTimeout, oXstart, oYstart,
         oBestX, oBestY, oBestScore} !== '0) begin
      failures++;
      $display("FAIL midwait_reset_outputs busy=%b cs=%b to=%b x=%0d y=%0d best=%0d, expected all 0",
               oBusy, oCorrStart, oTimeout, oXstart, oYstart, oBestScore);
    end
    iRST = 1'b0;
    @(negedge iCLK);
    stallTab[1] = 1'b0;
    randomScores(100);
    runSweep("after_midwait_reset", 1'b0);
  endtask

  task automatic test_back_to_back();
    clearTables();
    randomScores(200);
    runSweep("busy_start", 1'b1);
    randomScores(200);
    runSweep("second_sweep", 1'b0);
  endtask

  task automatic test_start_with_reset();
    int s0;
    s0 = startCnt;
    @(negedge iCLK);
    iRST = 1'b1;
    iStart = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    iStart = 1'b0;
    repeat (2) @(negedge iCLK);
    checks++;
    if (oBusy !== 1'b0 || startCnt != s0 || oValid !== 1'b0) begin
      failures++;
      $display("FAIL start_with_reset busy=%b valid=%b starts=%0d, expected 0 0 0",
               oBusy, oValid, startCnt - s0);
    end
  endtask

  initial begin
    clearTables();
    test_reset();
    test_directed();
    test_random();
    test_stale_finished();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    test_start_with_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
